// File: rtl/mult_div_unit.sv
// Iterative MIPS multiply/divide unit with HI/LO registers: shift-add MULT/MULTU and restoring DIV/DIVU over N+1 cycles.
// Define MDU_DIV_EN to build the divide datapath; without it divide starts are ignored.
module mult_div_unit #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start_i,
  input  logic [1:0]   op_i,
  input  logic [N-1:0] rs_data_i,
  input  logic [N-1:0] rt_data_i,
  input  logic [1:0]   hilo_we_i,
  output logic         busy_o,
  output logic         done_o,
  output logic [N-1:0] hi_o,
  output logic [N-1:0] lo_o
);

  localparam int CW = $clog2(N + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_FINISH = 2'd2;

  logic [1:0]     state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2*N-1:0] acc_q, acc_d;
  logic [N-1:0]   opnd_q, opnd_d;
  logic           neg_q, neg_d;
  logic [N-1:0]   hi_q, hi_d;
  logic [N-1:0]   lo_q, lo_d;
  logic           done_q, done_d;

  logic           start_ok;
  logic           rs_neg, rt_neg;
  logic [N-1:0]   rs_abs, rt_abs;
  logic [N:0]     mul_sum;
  logic [2*N-1:0] mul_next;
  logic [2*N-1:0] step_next;
  logic [2*N-1:0] prod_fix;

`ifdef MDU_DIV_EN
  logic           is_div_q, is_div_d;
  logic           rem_neg_q, rem_neg_d;
  logic           div_zero_q, div_zero_d;
  logic [N:0]     div_shift;
  logic           div_ge;
  logic [N-1:0]   div_diff;
  logic [2*N-1:0] div_next;
  logic [N-1:0]   quo_fix, rem_fix;
`endif

  // Signed ops run on magnitudes; signs are reapplied when the result is written.
  assign rs_neg = op_i[0] & rs_data_i[N-1];
  assign rt_neg = op_i[0] & rt_data_i[N-1];
  assign rs_abs = rs_neg ? (~rs_data_i + 1'b1) : rs_data_i;
  assign rt_abs = rt_neg ? (~rt_data_i + 1'b1) : rt_data_i;

`ifdef MDU_DIV_EN
  assign start_ok = start_i;
`else
  assign start_ok = start_i & ~op_i[1];
`endif

  // Multiply: acc = {partial, multiplier}; add multiplicand on LSB, shift right.
  assign mul_sum  = {1'b0, acc_q[2*N-1:N]} + (acc_q[0] ? {1'b0, opnd_q} : {(N+1){1'b0}});
  assign mul_next = {mul_sum, acc_q[N-1:1]};

`ifdef MDU_DIV_EN
  // Divide: acc = {remainder, dividend/quotient}; shift left, trial-subtract divisor.
  assign div_shift = {acc_q[2*N-1:N], acc_q[N-1]};
  assign div_ge    = (div_shift >= {1'b0, opnd_q});
  assign div_diff  = div_shift[N-1:0] - opnd_q;
  assign div_next  = {(div_ge ? div_diff : div_shift[N-1:0]), acc_q[N-2:0], div_ge};
  assign step_next = is_div_q ? div_next : mul_next;

  // A zero divisor leaves |dividend| in the remainder, so sign correction restores rs.
  assign quo_fix = div_zero_q ? {N{1'b1}} :
                   (neg_q ? (~acc_q[N-1:0] + 1'b1) : acc_q[N-1:0]);
  assign rem_fix = rem_neg_q ? (~acc_q[2*N-1:N] + 1'b1) : acc_q[2*N-1:N];
`else
  assign step_next = mul_next;
`endif

  assign prod_fix = neg_q ? (~acc_q + 1'b1) : acc_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    neg_d   = neg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
`ifdef MDU_DIV_EN
    is_div_d   = is_div_q;
    rem_neg_d  = rem_neg_q;
    div_zero_d = div_zero_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          state_d = S_RUN;
          cnt_d   = '0;
          neg_d   = rs_neg ^ rt_neg;
`ifdef MDU_DIV_EN
          is_div_d   = op_i[1];
          rem_neg_d  = rs_neg;
          div_zero_d = (rt_data_i == '0);
          opnd_d     = op_i[1] ? rt_abs : rs_abs;
          acc_d      = {{N{1'b0}}, (op_i[1] ? rs_abs : rt_abs)};
`else
          opnd_d     = rs_abs;
          acc_d      = {{N{1'b0}}, rt_abs};
`endif
        end else begin
          // Direct MTHI/MTLO writes only land when no operation is launched.
          if (hilo_we_i[1]) hi_d = rs_data_i;
          if (hilo_we_i[0]) lo_d = rs_data_i;
        end
      end
      S_RUN: begin
        acc_d = step_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(N - 1)) state_d = S_FINISH;
      end
      S_FINISH: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
`ifdef MDU_DIV_EN
        if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          hi_d = prod_fix[2*N-1:N];
          lo_d = prod_fix[N-1:0];
        end
`else
        hi_d = prod_fix[2*N-1:N];
        lo_d = prod_fix[N-1:0];
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      neg_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      neg_q   <= neg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

`ifdef MDU_DIV_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      is_div_q   <= 1'b0;
      rem_neg_q  <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      is_div_q   <= is_div_d;
      rem_neg_q  <= rem_neg_d;
      div_zero_q <= div_zero_d;
    end
  end
`endif

  assign busy_o = (state_q != S_IDLE);
  assign done_o = done_q;
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: arithmetic reference model checked every cycle, plus directed literal cases.
module tb_mult_div_unit;
  localparam int N = 32;
`ifdef MDU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start_i = 1'b0;
  logic [1:0]  op_i = 2'd0;
  logic [31:0] rs_data_i = '0;
  logic [31:0] rt_data_i = '0;
  logic [1:0]  hilo_we_i = 2'd0;
  logic        busy_o, done_o;
  logic [31:0] hi_o, lo_o;

  int total = 0;
  int bad = 0;

  mult_div_unit #(.N(N)) dut (
    .clk(clk), .reset(reset), .start_i(start_i), .op_i(op_i),
    .rs_data_i(rs_data_i), .rt_data_i(rt_data_i), .hilo_we_i(hilo_we_i),
    .busy_o(busy_o), .done_o(done_o), .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Result of one operation as {HI, LO}, straight from the arithmetic definition.
  function automatic logic [63:0] ref_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint unsigned ua, ub;
    longint sa, sb, p;
    ua = {32'd0, a};
    ub = {32'd0, b};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      2'd0: return ua * ub;
      2'd1: begin p = sa * sb; return p; end
      2'd2: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {32'(ua % ub), 32'(ua / ub)};
      end
      default: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {32'(sa % sb), 32'(sa / sb)};
      end
    endcase
  endfunction

  logic        exp_busy = 1'b0, exp_done = 1'b0;
  logic [31:0] exp_hi = '0, exp_lo = '0, pend_hi = '0, pend_lo = '0;
  int          remaining = 0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      exp_busy  <= 1'b0;
      exp_done  <= 1'b0;
      exp_hi    <= '0;
      exp_lo    <= '0;
      remaining <= 0;
    end else begin
      exp_done <= 1'b0;
      if (remaining > 0) begin
        remaining <= remaining - 1;
        if (remaining == 1) begin
          exp_busy <= 1'b0;
          exp_done <= 1'b1;
          exp_hi   <= pend_hi;
          exp_lo   <= pend_lo;
        end
      end else if (start_i && (DIV_EN || !op_i[1])) begin
        {pend_hi, pend_lo} <= ref_result(op_i, rs_data_i, rt_data_i);
        remaining <= N + 1;
        exp_busy  <= 1'b1;
      end else begin
        if (hilo_we_i[1]) exp_hi <= rs_data_i;
        if (hilo_we_i[0]) exp_lo <= rs_data_i;
      end
    end
  end

  always @(negedge clk) begin
    chk("busy", {63'd0, busy_o}, {63'd0, exp_busy});
    chk("done", {63'd0, done_o}, {63'd0, exp_done});
    chk("hi", {32'd0, hi_o}, {32'd0, exp_hi});
    chk("lo", {32'd0, lo_o}, {32'd0, exp_lo});
  end

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  // Launch one op, scramble operands during RUN, then check latency and result.
  task automatic do_op(input string name, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit accept, input bit disturb, input logic [31:0] ehi, input logic [31:0] elo);
    int cyc;
    start_i = 1'b1; op_i = op; rs_data_i = a; rt_data_i = b;
    @(posedge clk); #1;
    start_i = 1'b0; rs_data_i = $urandom; rt_data_i = $urandom;
    if (accept) begin
      cyc = 0;
      while (!done_o && cyc < 40) begin
        @(posedge clk); #1;
        cyc++;
        if (disturb && cyc == 5) begin
          start_i = 1'b1; op_i = 2'd0; hilo_we_i = 2'b11;
        end else begin
          start_i = 1'b0; hilo_we_i = 2'b00;
        end
      end
      chk({name, "_latency"}, 64'(cyc), 64'd33);
    end else begin
      chk({name, "_busy_ignored"}, {63'd0, busy_o}, 64'd0);
      repeat (3) @(posedge clk);
      #1;
    end
    chk({name, "_hi"}, {32'd0, hi_o}, {32'd0, ehi});
    chk({name, "_lo"}, {32'd0, lo_o}, {32'd0, elo});
    $display("op %s rs=%h rt=%h -> hi=%h lo=%h", name, a, b, hi_o, lo_o);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {63'd0, busy_o}, 64'd0);
    chk("rst_done", {63'd0, done_o}, 64'd0);
    chk("rst_hilo", {hi_o, lo_o}, 64'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    do_op("multu_max", 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFE, 32'h0000_0001);
    do_op("mult_neg", 2'd1, 32'hFFFF_FFFD, 32'd5, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
`ifdef MDU_DIV_EN
    do_op("divu", 2'd2, 32'd100, 32'd7, 1'b1, 1'b0, 32'd2, 32'd14);
    do_op("div_neg", 2'd3, 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    do_op("div_ovf", 2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'd0, 32'h8000_0000);
    do_op("divu_zero", 2'd2, 32'd5, 32'd0, 1'b1, 1'b0, 32'd5, 32'hFFFF_FFFF);
    do_op("div_zero_neg", 2'd3, 32'hFFFF_FFF0, 32'd0, 1'b1, 1'b0, 32'hFFFF_FFF0, 32'hFFFF_FFFF);
`else
    do_op("divu_off", 2'd2, 32'd5, 32'd0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
`endif

    hilo_we_i = 2'b10; rs_data_i = 32'h1234_5678;
    @(posedge clk); #1;
    chk("mthi_hi", {32'd0, hi_o}, {32'd0, 32'h1234_5678});
    chk("mthi_done", {63'd0, done_o}, 64'd0);
    hilo_we_i = 2'b01; rs_data_i = 32'h9ABC_DEF0;
    @(posedge clk); #1;
    hilo_we_i = 2'b00;
    chk("mtlo_lo", {32'd0, lo_o}, {32'd0, 32'h9ABC_DEF0});
    chk("mtlo_hi", {32'd0, hi_o}, {32'd0, 32'h1234_5678});
    chk("mtlo_done", {63'd0, done_o}, 64'd0);
    $display("hilo write hi=%h lo=%h", hi_o, lo_o);

    start_i = 1'b1; op_i = 2'd1; rs_data_i = 32'd7; rt_data_i = 32'd9;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("async_rst_busy", {63'd0, busy_o}, 64'd0);
    chk("async_rst_done", {63'd0, done_o}, 64'd0);
    chk("async_rst_hilo", {hi_o, lo_o}, 64'd0);
    $display("async reset mid-op busy=%b hi=%h lo=%h", busy_o, hi_o, lo_o);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    do_op("multu_small", 2'd0, 32'd6, 32'd7, 1'b1, 1'b0, 32'd0, 32'd42);

    for (int i = 0; i < 4000; i++) begin
      start_i   = ($urandom_range(0, 9) == 0);
      op_i      = 2'($urandom);
      rs_data_i = pick();
      rt_data_i = pick();
      hilo_we_i = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b00;
      reset     = ($urandom_range(0, 999) != 0);
      @(posedge clk); #1;
      if (done_o) $display("random op done hi=%h lo=%h", hi_o, lo_o);
    end
    reset = 1'b1; start_i = 1'b0; hilo_we_i = 2'b00;
    repeat (40) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
